// File: rtl/seq_arith_engine.sv
// Multicycle MUL (shift-add) / DIV (restoring) / GCD (subtractive) engine, start/busy/done handshake.
// Optional CYCLE_COUNT_EN adds a saturating Cycles output with the RUN length of the last operation.
module seq_arith_engine #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] InA,
   input  logic [WIDTH-1:0] InB,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] Out,
   output logic [WIDTH-1:0] OutHi
`ifdef CYCLE_COUNT_EN
   ,
   output logic [15:0]      Cycles
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   localparam logic [1:0] ModeMul = 2'b00;
   localparam logic [1:0] ModeDiv = 2'b01;
   localparam logic [1:0] ModeGcd = 2'b10;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [1:0]           mode_q, mode_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     out_q, out_d, out_hi_q, out_hi_d;
   logic                 err_q, err_d;
   logic                 fin;
   logic                 last;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_trial;
   logic [2*WIDTH-1:0]   div_next;

   // MUL: acc = {partial product high, remaining multiplier bits}, shifted right each cycle.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{acc_q[0]}}};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   // DIV: acc = {remainder, dividend/quotient}, shifted left; trial sign decides the quotient bit.
   assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
   assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign last = (cnt_q == 6'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      out_d    = out_q;
      out_hi_d = out_hi_q;
      err_d    = err_q;
      fin      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = InA;
               b_d     = InB;
               mode_d  = mode;
               cnt_d   = '0;
               acc_d   = {{WIDTH{1'b0}}, InA};
               err_d   = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            cnt_d = cnt_q + 6'd1;
            unique case (mode_q)
               ModeMul: begin
                  acc_d = mul_next;
                  if (last) begin
                     fin      = 1'b1;
                     out_d    = mul_next[WIDTH-1:0];
                     out_hi_d = mul_next[2*WIDTH-1:WIDTH];
                  end
               end
               ModeDiv: begin
                  if (b_q == '0) begin
                     fin      = 1'b1;
                     out_d    = '1;
                     out_hi_d = a_q;
                     err_d    = 1'b1;
                  end else begin
                     acc_d = div_next;
                     if (last) begin
                        fin      = 1'b1;
                        out_d    = div_next[WIDTH-1:0];
                        out_hi_d = div_next[2*WIDTH-1:WIDTH];
                     end
                  end
               end
               ModeGcd: begin
                  if (a_q == b_q || a_q == '0 || b_q == '0) begin
                     fin      = 1'b1;
                     out_d    = (a_q == '0) ? b_q : a_q;
                     out_hi_d = '0;
                  end else if (a_q > b_q) begin
                     a_d = a_q - b_q;
                  end else begin
                     b_d = b_q - a_q;
                  end
               end
               default: begin
                  fin      = 1'b1;
                  out_d    = '0;
                  out_hi_d = '0;
                  err_d    = 1'b1;
               end
            endcase
            if (fin) state_d = StFin;
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         out_hi_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         out_q    <= out_d;
         out_hi_q <= out_hi_d;
         err_q    <= err_d;
      end
   end

   assign busy  = (state_q != StIdle);
   assign done  = (state_q == StFin);
   assign err   = err_q;
   assign Out   = out_q;
   assign OutHi = out_hi_q;

`ifdef CYCLE_COUNT_EN
   logic [15:0] run_q, run_d, run_inc, cycles_q, cycles_d;

   assign run_inc = (run_q == 16'hFFFF) ? 16'hFFFF : run_q + 16'd1;

   always_comb begin
      run_d    = run_q;
      cycles_d = cycles_q;
      if (state_q == StIdle && start) run_d = '0;
      if (state_q == StRun) begin
         run_d = run_inc;
         if (fin) cycles_d = run_inc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q    <= '0;
         cycles_q <= '0;
      end else begin
         run_q    <= run_d;
         cycles_q <= cycles_d;
      end
   end

   assign Cycles = cycles_q;
`endif

endmodule
